// File: rtl/adc_i2c_scanner.sv
// I2C master that scans enabled ADC channels: one write-command / repeated-start / 2-byte-read
// transaction per channel. Define ADC_CLK_STRETCH_EN to honour slave clock stretching.
module adc_i2c_scanner #(
  parameter int unsigned CLK_DIV  = 125,
  parameter int unsigned N_CH     = 4,
  parameter int unsigned DATA_W   = 12,
  parameter logic [6:0]  DEV_ADDR = 7'h50,
  localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_CH-1:0]   ch_mask,
  output logic              busy,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              scl_oe,
  output logic              sda_oe,
  output logic              sample_valid,
  output logic [CH_W-1:0]   sample_ch,
  output logic [DATA_W-1:0] sample_data,
  output logic              nack_err
);

  typedef enum logic [3:0] {
    IDLE, START, ADDR_W, ACK_A, CMD, ACK_C, RSTART, ADDR_R,
    ACK_R, RD_HI, MACK, RD_LO, NMACK, STOP, NEXT
  } state_t;

  localparam logic [11:0] DIV_MAX = 12'(CLK_DIV - 1);

  state_t          state;
  logic [11:0]     div_cnt;
  logic [1:0]      qtr;
  logic [2:0]      bit_cnt;
  logic [7:0]      tx_byte;
  logic [7:0]      rx_byte;
  logic [7:0]      hi_byte;
  logic            ack_bit;
  logic [2:0]      cur_ch;
  logic [N_CH-1:0] mask_q;
  logic            abort;
  logic            bus_active;
  logic            hold;
  logic            tick;
  logic [3:0]      first_pick;
  logic [3:0]      next_pick;

  // Returns {found, index} of the lowest set bit of m at or above position from.
  function automatic logic [3:0] pick(input logic [N_CH-1:0] m, input int unsigned from);
    logic [3:0] r;
    r = '0;
    for (int unsigned i = N_CH; i > 0; i--)
      if ((i - 1) >= from && m[i - 1]) r = {1'b1, 3'(i - 1)};
    return r;
  endfunction

  function automatic logic [7:0] cmd_of(input logic [2:0] ch);
    if (!ch[2]) return 8'h10 << ch[1:0];
    return {1'b1, ch, 4'b0000};
  endfunction

`ifdef ADC_CLK_STRETCH_EN
  assign hold = qtr[1] & ~scl_i;
`else
  logic scl_unused;
  assign scl_unused = scl_i;
  assign hold       = 1'b0;
`endif

  assign bus_active = (state != IDLE) && (state != NEXT);
  assign tick       = bus_active && (div_cnt == DIV_MAX) && !hold;
  assign first_pick = pick(ch_mask, 0);
  assign next_pick  = pick(mask_q, 32'(cur_ch) + 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      div_cnt      <= '0;
      qtr          <= '0;
      bit_cnt      <= '0;
      tx_byte      <= '0;
      rx_byte      <= '0;
      hi_byte      <= '0;
      ack_bit      <= 1'b0;
      cur_ch       <= '0;
      mask_q       <= '0;
      abort        <= 1'b0;
      busy         <= 1'b0;
      scl_oe       <= 1'b0;
      sda_oe       <= 1'b0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
      nack_err     <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      nack_err     <= 1'b0;
      if (bus_active && !hold) div_cnt <= tick ? '0 : div_cnt + 12'd1;

      case (state)
        IDLE: begin
          if (start && |ch_mask) begin
            mask_q  <= ch_mask;
            cur_ch  <= first_pick[2:0];
            abort   <= 1'b0;
            busy    <= 1'b1;
            qtr     <= '0;
            div_cnt <= '0;
            state   <= START;
          end
        end

        NEXT: begin
          if (!abort) begin
            sample_valid <= 1'b1;
            sample_ch    <= cur_ch[CH_W-1:0];
            sample_data  <= DATA_W'({hi_byte, rx_byte});
          end
          qtr     <= '0;
          div_cnt <= '0;
          if (abort || !next_pick[3]) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cur_ch <= next_pick[2:0];
            state  <= START;
          end
        end

        default: begin
          if (tick) begin
            qtr <= qtr + 2'd1;
            // SCL is low in quarters 0-1 and released in 2-3; START keeps it released and
            // STOP leaves it released on exit so the bus idles high between transactions.
            case (qtr)
              2'd0: begin
                case (state)
                  ADDR_W, CMD, ADDR_R:                        sda_oe <= ~tx_byte[7];
                  ACK_A, ACK_C, ACK_R, RD_HI, RD_LO, NMACK,
                  RSTART:                                     sda_oe <= 1'b0;
                  MACK, STOP:                                 sda_oe <= 1'b1;
                  default: ;
                endcase
              end
              2'd1: begin
                scl_oe <= 1'b0;
                case (state)
                  START:               sda_oe  <= 1'b1;
                  RD_HI, RD_LO:        rx_byte <= {rx_byte[6:0], sda_i};
                  ACK_A, ACK_C, ACK_R: ack_bit <= sda_i;
                  default: ;
                endcase
              end
              2'd2: begin
                if (state == RSTART)    sda_oe <= 1'b1;
                else if (state == STOP) sda_oe <= 1'b0;
              end
              default: begin
                scl_oe <= (state != STOP);
                case (state)
                  START: begin
                    tx_byte <= {DEV_ADDR, 1'b0};
                    bit_cnt <= '0;
                    state   <= ADDR_W;
                  end
                  ADDR_W, CMD, ADDR_R, RD_HI, RD_LO: begin
                    if (bit_cnt == 3'd7) begin
                      bit_cnt <= '0;
                      case (state)
                        ADDR_W:  state <= ACK_A;
                        CMD:     state <= ACK_C;
                        ADDR_R:  state <= ACK_R;
                        RD_HI: begin
                          hi_byte <= rx_byte;
                          state   <= MACK;
                        end
                        default: state <= NMACK;
                      endcase
                    end else begin
                      bit_cnt <= bit_cnt + 3'd1;
                      tx_byte <= {tx_byte[6:0], 1'b0};
                    end
                  end
                  ACK_A, ACK_C, ACK_R: begin
                    if (ack_bit) begin
                      abort    <= 1'b1;
                      nack_err <= 1'b1;
                      state    <= STOP;
                    end else if (state == ACK_A) begin
                      tx_byte <= cmd_of(cur_ch);
                      state   <= CMD;
                    end else if (state == ACK_C) begin
                      state <= RSTART;
                    end else begin
                      state <= RD_HI;
                    end
                  end
                  RSTART: begin
                    tx_byte <= {DEV_ADDR, 1'b1};
                    state   <= ADDR_R;
                  end
                  MACK:    state <= RD_LO;
                  NMACK:   state <= STOP;
                  STOP:    state <= NEXT;
                  default: state <= IDLE;
                endcase
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_i2c_scanner.sv
// Directed bench for adc_i2c_scanner with a behavioural I2C slave on the bus.
module tb_adc_i2c_scanner;

  localparam int unsigned DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  ch_mask;
  logic        busy;
  logic        scl_i;
  logic        sda_i;
  logic        scl_oe;
  logic        sda_oe;
  logic        sample_valid;
  logic [1:0]  sample_ch;
  logic [11:0] sample_data;
  logic        nack_err;

  adc_i2c_scanner #(.CLK_DIV(DIV), .N_CH(4), .DATA_W(12), .DEV_ADDR(7'h50)) dut (
    .clk(clk), .rst(rst), .start(start), .ch_mask(ch_mask), .busy(busy),
    .scl_i(scl_i), .sda_i(sda_i), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
    .nack_err(nack_err)
  );

  always #5 clk = ~clk;

  // Bus lines: open drain, master and slave both pull low.
  logic sda_drv = 1'b0;
  logic stretch = 1'b0;
  wire  scl_m = ~scl_oe;
  wire  sda_l = ~(sda_oe | sda_drv);
  assign scl_i = ~(scl_oe | stretch);
  assign sda_i = sda_l;

  int         vectors = 0;
  int         miscompares = 0;

  // Slave model state
  int         mode = 0;       // 0 idle, 1 receiving, 2 transmitting
  int         bit_i = 0;
  int         byte_n = 0;
  logic [7:0] rx_sh = '0;
  logic       addr_ok = 1'b0;
  logic       rd_req = 1'b0;
  logic       mack = 1'b0;
  logic [7:0] cur_tx = '0;
  int         txn = 0;
  logic [7:0] hi_tab [4];
  logic [7:0] lo_tab [4];
  logic [7:0] rx_log [$];
  int         start_cnt = 0;
  int         stop_cnt = 0;
  logic       nack_addr = 1'b0;
  logic       stretch_en = 1'b0;
  logic       meas_pending = 1'b0;
  time        t_ack = 0;
  time        ack_period = 0;

  // Output monitors
  logic [1:0]  sv_ch [$];
  logic [11:0] sv_data [$];
  int          nack_run = 0;
  int          nack_pulses = 0;
  int          nack_max = 0;
  int          scl_rises = 0;
  logic        scl_prev = 1'b0;

  always @(negedge sda_l) if (scl_m === 1'b1) begin
    start_cnt++;
    mode = 1; bit_i = -1; byte_n = 0; sda_drv = 1'b0;
  end

  always @(posedge sda_l) if (scl_m === 1'b1) begin
    stop_cnt++;
    mode = 0;
  end

  always @(posedge scl_m) begin
    if (mode == 1 && bit_i >= 0 && bit_i < 8) rx_sh = {rx_sh[6:0], sda_l};
    if (mode == 2 && bit_i == 8) mack = ~sda_l;
  end

  always @(negedge scl_m) begin
    if (meas_pending) begin
      ack_period = $time - t_ack;
      meas_pending = 1'b0;
    end
    if (mode != 0) begin
      if (bit_i < 0) bit_i = 0;
      else begin
        bit_i = (bit_i == 8) ? 0 : bit_i + 1;
        if (mode == 1) begin
          if (bit_i == 8) begin
            rx_log.push_back(rx_sh);
            if (byte_n == 0) begin
              addr_ok = (rx_sh[7:1] == 7'h50) && !nack_addr;
              rd_req  = rx_sh[0];
              sda_drv = addr_ok;
            end else begin
              sda_drv = 1'b1;
              if (stretch_en) stretch = 1'b1;
              t_ack = $time;
              meas_pending = 1'b1;
            end
            byte_n++;
          end else if (bit_i == 0) begin
            sda_drv = 1'b0;
            if (byte_n == 1 && !addr_ok) mode = 0;
            else if (byte_n == 1 && rd_req) begin
              mode = 2;
              cur_tx = hi_tab[txn];
              sda_drv = ~cur_tx[7];
            end
          end
        end else begin
          if (bit_i >= 1 && bit_i <= 7) sda_drv = ~cur_tx[7 - bit_i];
          else if (bit_i == 8) sda_drv = 1'b0;
          else if (mack) begin
            cur_tx = lo_tab[txn];
            sda_drv = ~cur_tx[7];
          end else begin
            sda_drv = 1'b0;
            mode = 0;
            txn++;
          end
        end
      end
    end
  end

  // Slave holds SCL low for 20 clocks once the master releases it in the ACK_C bit.
  always @(negedge scl_oe) if (stretch) begin
    repeat (20) @(posedge clk);
    #1 stretch = 1'b0;
  end

  always @(negedge clk) begin
    if (sample_valid) begin
      sv_ch.push_back(sample_ch);
      sv_data.push_back(sample_data);
    end
    if (nack_err) begin
      nack_run++;
      if (nack_run == 1) nack_pulses++;
      if (nack_run > nack_max) nack_max = nack_run;
    end else nack_run = 0;
    if (scl_oe === 1'b1 && scl_prev === 1'b0) scl_rises++;
    scl_prev = scl_oe;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    sv_ch.delete(); sv_data.delete(); rx_log.delete();
    start_cnt = 0; stop_cnt = 0; nack_pulses = 0; nack_max = 0; txn = 0; scl_rises = 0;
  endtask

  task automatic run_scan(input logic [3:0] m, input int budget,
                          output logic busy_after, output int cycles);
    @(negedge clk); start = 1'b1; ch_mask = m;
    @(negedge clk); start = 1'b0; busy_after = busy;
    cycles = 0;
    while (busy && cycles < budget) begin
      @(negedge clk); cycles++;
    end
    repeat (2) @(negedge clk);
  endtask

  logic b_after;
  int   cyc;

  initial begin
    rst = 1'b1; start = 1'b0; ch_mask = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_nack", nack_err, 0);
    chk("rst_ch", sample_ch, 0);
    chk("rst_data", sample_data, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single channel 0, slave returns 0A/BC.
    clear_logs();
    hi_tab[0] = 8'h0A; lo_tab[0] = 8'hBC;
    run_scan(4'b0001, 3000, b_after, cyc);
    chk("s1_busy_rise", b_after, 1);
    chk("s1_done", cyc < 3000, 1);
    chk("s1_nsamples", sv_ch.size(), 1);
    chk("s1_ch", sv_ch[0], 0);
    chk("s1_data", sv_data[0], 12'hABC);
    chk("s1_nack", nack_pulses, 0);
    chk("s1_nbytes", rx_log.size(), 3);
    chk("s1_addr_w", rx_log[0], 8'hA0);
    chk("s1_cmd", rx_log[1], 8'h10);
    chk("s1_addr_r", rx_log[2], 8'hA1);
    chk("s1_stops", stop_cnt, 1);

    // Channels 1 and 3, with a start pulse and mask change mid-scan.
    clear_logs();
    hi_tab[0] = 8'h12; lo_tab[0] = 8'h34;
    hi_tab[1] = 8'h5F; lo_tab[1] = 8'hE1;
    @(negedge clk); start = 1'b1; ch_mask = 4'b1010;
    @(negedge clk); start = 1'b0;
    repeat (100) @(negedge clk);
    start = 1'b1; ch_mask = 4'b1111;
    @(negedge clk); start = 1'b0;
    chk("s2_busy_mid", busy, 1);
    cyc = 0;
    while (busy && cyc < 5000) begin
      @(negedge clk); cyc++;
    end
    chk("s2_done", cyc < 5000, 1);
    chk("s2_stops_at_idle", stop_cnt, 2);
    repeat (2) @(negedge clk);
    chk("s2_starts", start_cnt, 4);
    chk("s2_nsamples", sv_ch.size(), 2);
    chk("s2_ch0", sv_ch[0], 1);
    chk("s2_data0", sv_data[0], 12'h234);
    chk("s2_ch1", sv_ch[1], 3);
    chk("s2_data1", sv_data[1], 12'hFE1);
    chk("s2_cmd0", rx_log[1], 8'h20);
    chk("s2_cmd1", rx_log[4], 8'h80);
    chk("s2_hold_ch", sample_ch, 3);
    chk("s2_hold_data", sample_data, 12'hFE1);

    // Start with an empty mask is ignored.
    clear_logs();
    @(negedge clk); start = 1'b1; ch_mask = 4'b0000;
    @(negedge clk); start = 1'b0;
    chk("s3_busy", busy, 0);
    repeat (50) @(negedge clk);
    chk("s3_busy_late", busy, 0);
    chk("s3_no_scl", scl_rises, 0);
    chk("s3_no_start", start_cnt, 0);

    // Address NACK aborts the whole scan.
    clear_logs();
    nack_addr = 1'b1;
    run_scan(4'b0011, 3000, b_after, cyc);
    nack_addr = 1'b0;
    chk("s4_done", cyc < 3000, 1);
    chk("s4_nack_pulses", nack_pulses, 1);
    chk("s4_nack_width", nack_max, 1);
    chk("s4_nsamples", sv_ch.size(), 0);
    chk("s4_stops", stop_cnt, 1);
    chk("s4_starts", start_cnt, 1);
    chk("s4_nbytes", rx_log.size(), 1);
    chk("s4_sda_idle", sda_oe, 0);

    // Reset while the high data byte is being read.
    clear_logs();
    hi_tab[0] = 8'hC3; lo_tab[0] = 8'h5A;
    @(negedge clk); start = 1'b1; ch_mask = 4'b0001;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!(mode == 2 && bit_i == 3 && scl_oe) && cyc < 3000) begin
      @(negedge clk); cyc++;
    end
    chk("s5_reach_rdhi", cyc < 3000, 1);
    rst = 1'b1;
    #1;
    chk("s5_scl_rel", scl_oe, 0);
    chk("s5_sda_rel", sda_oe, 0);
    chk("s5_busy", busy, 0);
    mode = 0; sda_drv = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    clear_logs();
    run_scan(4'b0001, 3000, b_after, cyc);
    chk("s5_done", cyc < 3000, 1);
    chk("s5_nsamples", sv_ch.size(), 1);
    chk("s5_ch", sv_ch[0], 0);
    chk("s5_data", sv_data[0], 12'h35A);

    // Slave stretches SCL in the command ACK bit.
    clear_logs();
    hi_tab[0] = 8'h7E; lo_tab[0] = 8'h01;
    stretch_en = 1'b1;
    run_scan(4'b0100, 3000, b_after, cyc);
    stretch_en = 1'b0;
    chk("s6_done", cyc < 3000, 1);
    chk("s6_cmd", rx_log[1], 8'h40);
    chk("s6_nsamples", sv_ch.size(), 1);
    chk("s6_ch", sv_ch[0], 2);
    chk("s6_data", sv_data[0], 12'hE01);
`ifdef ADC_CLK_STRETCH_EN
    chk("s6_ack_period", 32'(ack_period), 32'((4 * DIV + 20) * 10));
`else
    chk("s6_ack_period", 32'(ack_period), 32'((4 * DIV) * 10));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adc_i2c_scanner.md
ADC_I2C_SCANNER -- requirements
Module: adc_i2c_scanner

Interface
REQ-001 SHALL have parameter CLK_DIV, default 125, meaning clk cycles per SCL quarter-period (range 2..4095).
REQ-002 SHALL have parameter N_CH, default 4, meaning number of ADC channels scanned (range 1..8).
REQ-003 SHALL have parameter DATA_W, default 12, meaning sample width (range 8..16).
REQ-004 SHALL have parameter DEV_ADDR, default 7'h50, meaning 7-bit I2C device address.
REQ-005 SHALL have port clk, input, 1, system clock; reset rst, asynchronous, active-high; clock clk.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1, single-cycle scan request.
REQ-008 SHALL have port ch_mask, input, N_CH, channel enable bits, sampled when start is accepted.
REQ-009 SHALL have port busy, output, 1, scan in progress.
REQ-010 SHALL have ports scl_i and sda_i, input, 1 each, bus line levels (externally synchronised).
REQ-011 SHALL have ports scl_oe and sda_oe, output, 1 each, 1 = pull line low, 0 = release.
REQ-012 SHALL have port sample_valid, output, 1, one-cycle pulse qualifying sample_ch/sample_data.
REQ-013 SHALL have port sample_ch, output, max(1,$clog2(N_CH)), channel index of the sample.
REQ-014 SHALL have port sample_data, output, DATA_W, conversion result.
REQ-015 SHALL have port nack_err, output, 1, one-cycle pulse on any missing slave ACK.

Function
REQ-016 SHALL derive a quarter-tick every CLK_DIV clk cycles; each SCL bit = 4 ticks (low, low, high, high); divider runs only while busy.
REQ-017 SHALL use FSM states IDLE, START, ADDR_W, ACK_A, CMD, ACK_C, RSTART, ADDR_R, ACK_R, RD_HI, MACK, RD_LO, NMACK, STOP, NEXT.
REQ-018 SHALL accept start only in IDLE with ch_mask != 0; otherwise start is ignored and busy stays 0.
REQ-019 SHALL assert busy the cycle after acceptance until the cycle the FSM re-enters IDLE.
REQ-020 SHALL serve enabled channels in ascending index order, one full transaction per channel.
REQ-021 Transaction: START; byte {DEV_ADDR,0}; command byte with bit (4+ch) set for ch<4, or {1'b1,ch[2:0],4'b0} for ch>=4; RSTART; byte {DEV_ADDR,1}; read high byte, master ACK; read low byte, master NACK; STOP.
REQ-022 SHALL shift bits MSB first; change SDA only while SCL low; sample sda_i at the rising-edge tick of SCL high.
REQ-023 SHALL form sample_data = {hi,lo}[DATA_W-1:0] and pulse sample_valid one cycle after STOP completes, sample_ch = channel index.
REQ-024 On sda_i high in ACK_A, ACK_C or ACK_R: SHALL go to STOP, pulse nack_err once, abort remaining channels, no sample_valid for that channel.
REQ-025 SHALL keep sample_ch/sample_data stable between sample_valid pulses.
REQ-026 start during busy SHALL be ignored; ch_mask changes during busy SHALL have no effect.

Reset
REQ-027 On rst: state IDLE, divider 0, scl_oe=0, sda_oe=0, busy=0, sample_valid=0, nack_err=0, sample_ch=0, sample_data=0, immediately (asynchronous).
REQ-028 rst mid-transaction SHALL release both lines in the same cycle; next start SHALL begin a fresh scan from the lowest enabled channel.

Configuration
REQ-029 With macro ADC_CLK_STRETCH_EN defined: during SCL-high quarter-ticks the divider SHALL hold while scl_i=0 (slave stretch), resuming when scl_i=1.
REQ-030 Without ADC_CLK_STRETCH_EN: scl_i SHALL be ignored and SCL timing SHALL be purely divider-based.

Verification
REQ-031 CLK_DIV=4, ch_mask=4'b0001, slave ACKs, returns 8'h0A,8'hBC -> one sample_valid, sample_ch=0, sample_data=12'hABC, nack_err=0.
REQ-032 ch_mask=4'b1010 -> two transactions, command bytes 8'h20 then 8'h80, sample_ch 1 then 3, busy drops after second STOP.
REQ-033 Slave NACKs address byte -> STOP on bus, nack_err pulse of 1 cycle, no sample_valid, busy returns to 0.
REQ-034 start with ch_mask=0, and start pulse mid-scan -> busy unchanged, no extra bus activity.
REQ-035 rst asserted during RD_HI -> scl_oe=0, sda_oe=0 same cycle; later start completes normal scan.
REQ-036 ADC_CLK_STRETCH_EN defined, slave holds scl_i low 20 cycles during ACK_C -> bit period extended by 20 cycles, data correct; undefined -> no extension.
